// File: rtl/spi_mem_arbiter.sv
// Two-requester round-robin arbiter in front of the SPI flash command engine, with flash power-up sequencing.
// Optional WAIT timeout/abort enabled by defining SPI_MEM_ARB_TIMEOUT_EN.
module spi_mem_arbiter #(
  parameter int PWR_DELAY = 2000,
  parameter int ADDR_W    = 24,
  parameter int LEN_W     = 16,
  parameter int TIMEOUT   = 65535
) (
  input  logic              CLKA,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  input  logic [7:0]        req0_cmd,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [LEN_W-1:0]  req0_len,
  input  logic [7:0]        req1_cmd,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [LEN_W-1:0]  req1_len,
  output logic [1:0]        req_ack,
  output logic [1:0]        req_done,
  output logic [1:0]        grant,
  output logic              eng_start,
  output logic [7:0]        eng_cmd,
  output logic [ADDR_W-1:0] eng_addr,
  output logic [LEN_W-1:0]  eng_len,
  input  logic              eng_done,
  output logic              MEM_VCC,
  output logic              mem_ready,
  output logic              err_timeout
);

  typedef enum logic [1:0] {S_PWR_UP, S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam int PW = $clog2(PWR_DELAY + 1);

  state_t        state, state_nx;
  logic [PW-1:0] pwr_cnt;
  logic          rr;       // requester that wins a tie
  logic          win;      // 0 = requester 0, 1 = requester 1
  logic          accept;
  logic          finish;

`ifdef SPI_MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  logic          abort;
  logic          err_q;
`endif

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    finish   = 1'b0;
`ifdef SPI_MEM_ARB_TIMEOUT_EN
    abort    = 1'b0;
`endif
    win      = (&req_valid) ? rr : req_valid[1];
    case (state)
      // the settle count only starts once the supply is actually on
      S_PWR_UP: if (MEM_VCC && pwr_cnt == PW'(PWR_DELAY - 1)) state_nx = S_IDLE;
      S_IDLE: if (|req_valid) begin
        accept   = 1'b1;
        state_nx = S_ISSUE;
      end
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        if (eng_done) begin
          finish   = 1'b1;
          state_nx = S_IDLE;
        end
`ifdef SPI_MEM_ARB_TIMEOUT_EN
        else if (wait_cnt == TW'(TIMEOUT - 1)) begin
          finish   = 1'b1;
          abort    = 1'b1;
          state_nx = S_IDLE;
        end
`endif
      end
      default: state_nx = S_PWR_UP;
    endcase
  end

  always_ff @(posedge CLKA) begin
    if (!rst_n) begin
      state <= S_PWR_UP;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge CLKA) begin
    if (!rst_n) begin
      pwr_cnt   <= '0;
      rr        <= 1'b0;
      req_ack   <= 2'b00;
      req_done  <= 2'b00;
      grant     <= 2'b00;
      eng_start <= 1'b0;
      eng_cmd   <= '0;
      eng_addr  <= '0;
      eng_len   <= '0;
      MEM_VCC   <= 1'b0;
      mem_ready <= 1'b0;
    end else begin
      MEM_VCC   <= 1'b1;
      req_ack   <= 2'b00;
      req_done  <= 2'b00;
      eng_start <= 1'b0;
      if (state == S_PWR_UP && MEM_VCC) pwr_cnt <= pwr_cnt + 1'b1;
      if (state == S_PWR_UP && state_nx == S_IDLE) mem_ready <= 1'b1;
      if (accept) begin
        eng_cmd  <= win ? req1_cmd  : req0_cmd;
        eng_addr <= win ? req1_addr : req0_addr;
        eng_len  <= win ? req1_len  : req0_len;
        grant    <= win ? 2'b10 : 2'b01;
        req_ack  <= win ? 2'b10 : 2'b01;
        rr       <= ~win;
      end
      if (state == S_ISSUE) eng_start <= 1'b1;
      if (finish) begin
        req_done <= grant;
        grant    <= 2'b00;
      end
    end
  end

`ifdef SPI_MEM_ARB_TIMEOUT_EN
  always_ff @(posedge CLKA) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= (state == S_WAIT && state_nx == S_WAIT) ? wait_cnt + 1'b1 : '0;
      if (abort) err_q <= 1'b1;
    end
  end
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Scoreboard bench for spi_mem_arbiter: stimulus pushes expected ack/start/done events, a monitor pops and compares.
module tb_spi_mem_arbiter;

  localparam int K_ACK = 0, K_START = 1, K_DONE = 2;

  typedef struct {
    int          kind;
    logic [1:0]  who;
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [15:0] len;
  } exp_t;

  logic        CLKA = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [7:0]  req0_cmd, req1_cmd;
  logic [23:0] req0_addr, req1_addr;
  logic [15:0] req0_len, req1_len;
  logic [1:0]  req_ack, req_done, grant;
  logic        eng_start, eng_done;
  logic [7:0]  eng_cmd;
  logic [23:0] eng_addr;
  logic [15:0] eng_len;
  logic        MEM_VCC, mem_ready, err_timeout;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_ack = 0;
  bit   eng_auto = 1'b0;
  int   eng_delay = 10;
  exp_t sbq[$];

  spi_mem_arbiter #(.PWR_DELAY(20), .ADDR_W(24), .LEN_W(16), .TIMEOUT(100)) dut (
    .CLKA(CLKA), .rst_n(rst_n), .req_valid(req_valid),
    .req0_cmd(req0_cmd), .req0_addr(req0_addr), .req0_len(req0_len),
    .req1_cmd(req1_cmd), .req1_addr(req1_addr), .req1_len(req1_len),
    .req_ack(req_ack), .req_done(req_done), .grant(grant),
    .eng_start(eng_start), .eng_cmd(eng_cmd), .eng_addr(eng_addr), .eng_len(eng_len),
    .eng_done(eng_done), .MEM_VCC(MEM_VCC), .mem_ready(mem_ready), .err_timeout(err_timeout)
  );

  always #5 CLKA = ~CLKA;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_cmd(input logic [1:0] who, input logic [7:0] cmd, input logic [23:0] addr,
                          input logic [15:0] len, input bit with_done);
    exp_t e;
    e.who = who; e.cmd = cmd; e.addr = addr; e.len = len;
    e.kind = K_ACK;   sbq.push_back(e);
    e.kind = K_START; sbq.push_back(e);
    if (with_done) begin
      e.kind = K_DONE; sbq.push_back(e);
    end
  endtask

  task automatic pop_exp(input int kind, output exp_t e, output bit ok);
    ok = 1'b0;
    e.kind = -1; e.who = '0; e.cmd = '0; e.addr = '0; e.len = '0;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: kind %0d seen, expected none (cycle %0d)", kind, cyc);
    end else begin
      e  = sbq.pop_front();
      ok = 1'b1;
      chk("event_kind", e.kind, kind);
    end
  endtask

  // monitor: outputs are sampled on the falling edge, well away from CLKA rising
  always @(negedge CLKA) begin
    exp_t e;
    bit   ok;
    cyc++;
    if (req_ack != 2'b00) begin
      pop_exp(K_ACK, e, ok);
      if (ok) begin
        chk("ack_who", req_ack, e.who);
        chk("ack_grant", grant, e.who);
      end
      last_ack = cyc;
    end
    if (eng_start === 1'b1) begin
      pop_exp(K_START, e, ok);
      if (ok) begin
        chk("start_cmd", eng_cmd, e.cmd);
        chk("start_addr", eng_addr, e.addr);
        chk("start_len", eng_len, e.len);
        chk("start_latency", cyc - last_ack, 1);
      end
    end
    if (req_done != 2'b00) begin
      pop_exp(K_DONE, e, ok);
      if (ok) begin
        chk("done_who", req_done, e.who);
        chk("done_grant_clr", grant, 2'b00);
        chk("done_cmd_held", eng_cmd, e.cmd);
      end
    end
  end

  // engine model: one-cycle done a fixed delay after each start
  always @(negedge CLKA) begin
    if (eng_start === 1'b1 && eng_auto) begin
      repeat (eng_delay) @(posedge CLKA);
      #1 eng_done = 1'b1;
      @(posedge CLKA);
      #1 eng_done = 1'b0;
    end
  end

  // sel 0 waits for req_ack, sel 1 for req_done; returns at the negedge where it is seen
  task automatic wait_pulse(input int sel, input string nm);
    int n = 0;
    do begin
      @(negedge CLKA);
      n++;
    end while (((sel == 0) ? req_ack : req_done) == 2'b00 && n < 400);
    if (((sel == 0) ? req_ack : req_done) == 2'b00) begin
      checks++;
      errors++;
      $display("FAIL %s: no pulse within %0d cycles", nm, n);
    end
  endtask

  // called right after rst_n is released at a negedge
  task automatic pwr_seq(input string nm);
    @(negedge CLKA);
    chk({nm, "_vcc_on"}, MEM_VCC, 1'b1);
    chk({nm, "_ready_early"}, mem_ready, 1'b0);
    repeat (19) @(negedge CLKA);
    chk({nm, "_ready_19"}, mem_ready, 1'b0);
    @(negedge CLKA);
    chk({nm, "_ready_20"}, mem_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; eng_done = 1'b0;
    req0_cmd = '0; req0_addr = '0; req0_len = '0;
    req1_cmd = '0; req1_addr = '0; req1_len = '0;
    repeat (3) @(negedge CLKA);
    chk("rst_vcc", MEM_VCC, 1'b0);
    chk("rst_ready", mem_ready, 1'b0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_start", eng_start, 1'b0);
    chk("rst_err", err_timeout, 1'b0);

    // power-up with a request already pending; it must not be acked early
    rst_n = 1'b1;
    req0_cmd = 8'h02; req0_addr = 24'h000100; req0_len = 16'd256;
    req_valid = 2'b01;
    pwr_seq("pwr");
    push_cmd(2'b01, 8'h02, 24'h000100, 16'd256, 1'b1);
    eng_auto = 1'b1; eng_delay = 50;
    wait_pulse(0, "single_ack");
    req_valid = 2'b00;
    wait_pulse(1, "single_done");

    // req1 arrives while req0 owns the engine
    eng_delay = 10;
    req0_cmd = 8'h20; req0_addr = 24'h010000; req0_len = 16'd1;
    req1_cmd = 8'h03; req1_addr = 24'h000200; req1_len = 16'd64;
    push_cmd(2'b01, 8'h20, 24'h010000, 16'd1, 1'b1);
    push_cmd(2'b10, 8'h03, 24'h000200, 16'd64, 1'b1);
    req_valid = 2'b01;
    wait_pulse(0, "wait_req0_ack");
    req_valid = 2'b00;
    repeat (3) @(negedge CLKA);
    req_valid = 2'b10;
    wait_pulse(0, "wait_req1_ack");
    req_valid = 2'b00;
    wait_pulse(1, "wait_req1_done");

    // both held: strict alternation, len 0 passes through
    req0_cmd = 8'h03; req0_addr = 24'h001000; req0_len = 16'd16;
    req1_cmd = 8'h0B; req1_addr = 24'hABCDEF; req1_len = 16'd0;
    for (int i = 0; i < 4; i++)
      if (i % 2 == 0) push_cmd(2'b01, 8'h03, 24'h001000, 16'd16, 1'b1);
      else            push_cmd(2'b10, 8'h0B, 24'hABCDEF, 16'd0, 1'b1);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) wait_pulse(1, "rr_done");
    req_valid = 2'b00;
    repeat (3) @(negedge CLKA);

    // stray engine done while idle
    eng_done = 1'b1;
    @(negedge CLKA);
    eng_done = 1'b0;
    chk("idle_done_ignored", req_done, 2'b00);
    chk("idle_grant", grant, 2'b00);
    repeat (2) @(negedge CLKA);

    // reset in the middle of a command
    eng_auto = 1'b0;
    req0_cmd = 8'h05; req0_addr = 24'h123456; req0_len = 16'd3;
    push_cmd(2'b01, 8'h05, 24'h123456, 16'd3, 1'b0);
    req_valid = 2'b01;
    wait_pulse(0, "midrst_ack");
    repeat (5) @(negedge CLKA);
    chk("midrst_grant_before", grant, 2'b01);
    rst_n = 1'b0;
    @(negedge CLKA);
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_ready", mem_ready, 1'b0);
    chk("midrst_vcc", MEM_VCC, 1'b0);
    rst_n = 1'b1;
    pwr_seq("repwr");
    push_cmd(2'b01, 8'h05, 24'h123456, 16'd3, 1'b1);
    eng_auto = 1'b1; eng_delay = 5;
    wait_pulse(0, "repwr_ack");
    req_valid = 2'b00;
    wait_pulse(1, "repwr_done");

    repeat (5) @(negedge CLKA);
    chk("sb_empty", sbq.size(), 0);
    chk("err_timeout_low", err_timeout, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_mem_arbiter.md
Name: spi_mem_arbiter

Overview:
- Shares the single SPI flash command engine between two requesters: FIFO write-back (req0) and UART read-out (req1).
- Sequences memory power-up: drives MEM_VCC, waits a settle delay, then reports mem_ready (exported as MEM_CM_READY).
- Issues one command at a time to the engine, holds the grant until the engine signals done, then re-arbitrates round-robin.
- Sits between the FIFO/UART control logic and the SPI command engine inside top.

Parameters:
- PWR_DELAY, 2000, CLKA cycles between MEM_VCC rising and mem_ready rising (2000 = 100 us at 20 MHz).
- ADDR_W, 24, flash address width.
- LEN_W, 16, transfer byte-count width.
- TIMEOUT, 65535, max cycles in WAIT before abort (optional feature only).

Ports:
- CLKA  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  2  request per requester; bit0 = FIFO, bit1 = UART; held until accepted
- req0_cmd  in  8  SPI opcode for requester 0
- req0_addr  in  ADDR_W  address for requester 0
- req0_len  in  LEN_W  byte count for requester 0
- req1_cmd  in  8  SPI opcode for requester 1
- req1_addr  in  ADDR_W  address for requester 1
- req1_len  in  LEN_W  byte count for requester 1
- req_ack  out  2  one-cycle pulse: request accepted (one-hot)
- req_done  out  2  one-cycle pulse: command complete for owner
- grant  out  2  one-hot current owner; 0 when none
- eng_start  out  1  one-cycle start pulse to the engine
- eng_cmd  out  8  registered opcode
- eng_addr  out  ADDR_W  registered address
- eng_len  out  LEN_W  registered byte count
- eng_done  in  1  one-cycle completion pulse from the engine
- MEM_VCC  out  1  flash supply enable
- mem_ready  out  1  memory powered and settled
- err_timeout  out  1  sticky abort flag (optional feature only; otherwise tied 0)

Behaviour:
- Reset (rst_n == 0 at a CLKA edge):
  - All outputs 0; state = PWR_UP; power counter = 0; round-robin pointer = requester 0.
- PWR_UP:
  - MEM_VCC = 1 from the first cycle after reset release.
  - Counter increments each cycle; at count == PWR_DELAY-1, move to IDLE and set mem_ready = 1 on the next edge.
  - Requests are ignored (not acked) while in PWR_UP.
- IDLE:
  - If any req_valid bit is set, pick the winner.
  - If both are set, the winner is the requester indicated by the rr pointer; the pointer then moves to the other requester.
  - If only one is set, it wins, and the pointer moves to the other requester.
  - On the same edge: latch the winner's cmd/addr/len into the eng_* registers, set grant one-hot, pulse req_ack for the winner, go to ISSUE.
- ISSUE:
  - eng_start = 1 for exactly one cycle, then go to WAIT.
  - Latency: req_valid sampled in IDLE → eng_start high 2 edges later.
- WAIT:
  - Hold grant and the eng_* values stable until eng_done = 1.
  - On eng_done: pulse req_done for the owner, clear grant on the next edge, return to IDLE.
  - A new request can be accepted on the cycle after return to IDLE, so the minimum gap from eng_done to the next eng_start is 3 cycles.
- Boundary conditions:
  - eng_done outside WAIT is ignored.
  - req_valid dropped before ack: no effect; requests are sampled only in IDLE.
  - The owner's req_valid staying high after ack does not re-request; it is treated as a new request only once the arbiter is back in IDLE.
  - With both requesters continuously requesting, grants alternate 0,1,0,1.
  - eng_len == 0 is passed through unchanged; the arbiter does not check it.
  - rst_n low mid-command: immediate return to the reset state. MEM_VCC drops to 0 for the reset cycle and the full PWR_UP delay is repeated.

Optional Feature:
- Macro: SPI_MEM_ARB_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter starts at 0 on entry to WAIT.
  - If it reaches TIMEOUT without eng_done: set err_timeout = 1 (sticky until reset), pulse req_done for the owner, clear grant, return to IDLE.
  - eng_done on the same cycle as timeout counts as a normal completion; err_timeout is not set.
- Undefined:
  - No timeout counter; WAIT waits indefinitely; err_timeout is tied 0.

Test Plan:
- Reset, then idle (PWR_DELAY = 20):
  - MEM_VCC = 1 one cycle after rst_n release.
  - mem_ready = 1 exactly 20 cycles later.
  - A req_valid = 01 raised during PWR_UP is acked only after mem_ready.
- Single request req0 (cmd 0x02, addr 0x000100, len 256):
  - req_ack = 01, then eng_start 1 cycle later with eng_cmd/addr/len matching.
  - eng_done 50 cycles later → req_done = 01; grant returns to 00.
- Both requesters held high (req_valid = 11) for 4 commands, eng_done 10 cycles after each start:
  - Grant order 01, 10, 01, 10; each req_done matches its ack.
- Engine-side edge cases:
  - eng_done pulsed while in IDLE → no req_done, no state change.
  - New req1 during WAIT of req0 → acked only after req0's req_done.
- Reset mid-command:
  - rst_n low for 1 cycle during WAIT → grant = 00, mem_ready = 0, MEM_VCC = 0 for that cycle.
  - Power-up repeats; the pending request is acked only after the new mem_ready.
- With SPI_MEM_ARB_TIMEOUT_EN defined, TIMEOUT = 100, engine never sends done:
  - After 100 WAIT cycles: err_timeout = 1 and req_done pulses for the owner.
  - A following request completes normally; err_timeout stays 1 until reset.
